// File: rtl/video_timing_pkg.sv
// Shared constants for the raster timing generator: 480p defaults, position
// widths, FSM state encodings and the debug view of the controller.
package video_timing_pkg;

  localparam int H_POS_W = 11;
  localparam int V_POS_W = 10;

  localparam int DEF_H_ACTIVE = 720;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 62;
  localparam int DEF_H_BP     = 60;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 9;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 30;
  localparam int DEF_FC_W     = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [1:0] state;
    logic       v_at_top;
  } vtg_dbg_t;

endpackage

// File: rtl/vtg_axis_counter.sv
// One raster axis: signed wrap counter START..LAST with advance enable and
// hold-at-start, plus sync-window / at-start / at-last flags registered with it.
module vtg_axis_counter #(
  parameter int W       = 11,
  parameter int START   = -138,
  parameter int LAST    = 719,
  parameter int SYNC_LO = -122,
  parameter int SYNC_HI = -61
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_adv,
  input  logic                i_hold,
  input  logic                i_active,
  output logic signed [W-1:0] o_pos,
  output logic signed [W-1:0] o_pos_next,
  output logic                o_in_sync,
  output logic                o_at_start,
  output logic                o_at_last
);

  localparam logic signed [W-1:0] P_START   = W'(START);
  localparam logic signed [W-1:0] P_LAST    = W'(LAST);
  localparam logic signed [W-1:0] P_SYNC_LO = W'(SYNC_LO);
  localparam logic signed [W-1:0] P_SYNC_HI = W'(SYNC_HI);
  localparam logic signed [W-1:0] P_ONE     = W'(1);

  logic signed [W-1:0] r_pos;
  logic signed [W-1:0] w_next;
  logic                r_in_sync;
  logic                r_at_start;
  logic                r_at_last;

  always_comb begin
    w_next = r_pos;
    if (i_hold) begin
      w_next = P_START;
    end else if (i_adv) begin
      w_next = (r_pos == P_LAST) ? P_START : r_pos + P_ONE;
    end
  end

  // Flags are computed from the next position so they line up with o_pos.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos      <= P_START;
      r_in_sync  <= 1'b0;
      r_at_start <= 1'b0;
      r_at_last  <= 1'b0;
    end else begin
      r_pos      <= w_next;
      r_in_sync  <= i_active && (w_next >= P_SYNC_LO) && (w_next <= P_SYNC_HI);
      r_at_start <= i_active && (w_next == P_START);
      r_at_last  <= i_active && (w_next == P_LAST);
    end
  end

  assign o_pos      = r_pos;
  assign o_pos_next = w_next;
  assign o_in_sync  = r_in_sync;
  assign o_at_start = r_at_start;
  assign o_at_last  = r_at_last;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator (signed positions, syncs, enables, strobes, frame count).
// Optional VTG_LOOKAHEAD_EN adds hPosNext/vPosNext = position on the next clock.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int FC_W     = DEF_FC_W
) (
  input  logic                      pixelClock,
  input  logic                      reset_n,
  input  logic                      run,
  output logic signed [H_POS_W-1:0] hPosCounter,
  output logic signed [V_POS_W-1:0] vPosCounter,
`ifdef VTG_LOOKAHEAD_EN
  output logic signed [H_POS_W-1:0] hPosNext,
  output logic signed [V_POS_W-1:0] vPosNext,
`endif
  output logic                      hSync,
  output logic                      vSync,
  output logic                      inActiveDisplay,
  output logic                      lineStart,
  output logic                      frameStart,
  output logic [FC_W-1:0]           frameCount,
  output logic                      running,
  output vtg_dbg_t                  o_dbg
);

  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;
  localparam logic [FC_W-1:0] FC_ONE = FC_W'(1);

  if ((H_ACTIVE - 1 > 1023) || (H_BLANK > 1024) ||
      (V_ACTIVE - 1 > 511) || (V_BLANK > 512)) begin : g_bad_range
    $error("video_timing_gen: raster positions do not fit the signed position ports");
  end

  logic [1:0]                r_state;
  logic [1:0]                w_state_next;
  logic                      w_adv;
  logic                      w_hold;
  logic                      w_active_next;
  logic                      w_frame_end;
  logic signed [H_POS_W-1:0] w_h_next;
  logic signed [V_POS_W-1:0] w_v_next;
  logic                      w_h_at_last;
  logic                      w_v_at_last;
  logic                      w_v_at_top;
  logic                      r_running;
  logic                      r_active;
  logic                      r_frame_start;
  logic [FC_W-1:0]           r_frame_count;

  // Counter motion depends only on the registered state, never on run, so the
  // IDLE->RUN first cycle repeats the start position and DRAIN ends on the wrap.
  assign w_adv         = (r_state != ST_IDLE);
  assign w_hold        = (r_state == ST_IDLE);
  assign w_frame_end   = w_h_at_last && w_v_at_last;
  assign w_active_next = (w_state_next != ST_IDLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (run) w_state_next = ST_RUN;
      ST_RUN:   if (!run) w_state_next = w_frame_end ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (run)              w_state_next = ST_RUN;
        else if (w_frame_end) w_state_next = ST_IDLE;
      end
      default:  w_state_next = ST_IDLE;
    endcase
  end

  vtg_axis_counter #(
    .W(H_POS_W), .START(-H_BLANK), .LAST(H_ACTIVE - 1),
    .SYNC_LO(-(H_SYNC + H_BP)), .SYNC_HI(-H_BP - 1)
  ) u_h_cnt (
    .i_clk(pixelClock), .i_rst_n(reset_n), .i_adv(w_adv), .i_hold(w_hold),
    .i_active(w_active_next), .o_pos(hPosCounter), .o_pos_next(w_h_next),
    .o_in_sync(hSync), .o_at_start(lineStart), .o_at_last(w_h_at_last)
  );

  vtg_axis_counter #(
    .W(V_POS_W), .START(-V_BLANK), .LAST(V_ACTIVE - 1),
    .SYNC_LO(-(V_SYNC + V_BP)), .SYNC_HI(-V_BP - 1)
  ) u_v_cnt (
    .i_clk(pixelClock), .i_rst_n(reset_n), .i_adv(w_adv && w_h_at_last),
    .i_hold(w_hold), .i_active(w_active_next), .o_pos(vPosCounter),
    .o_pos_next(w_v_next), .o_in_sync(vSync), .o_at_start(w_v_at_top),
    .o_at_last(w_v_at_last)
  );

  always_ff @(posedge pixelClock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_running     <= 1'b0;
      r_active      <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_running     <= w_active_next;
      r_active      <= w_active_next && !w_h_next[H_POS_W-1] && !w_v_next[V_POS_W-1];
      r_frame_start <= w_active_next && (w_h_next == '0) && (w_v_next == '0);
      if (w_frame_end) r_frame_count <= r_frame_count + FC_ONE;
    end
  end

  assign running         = r_running;
  assign inActiveDisplay = r_active;
  assign frameStart      = r_frame_start;
  assign frameCount      = r_frame_count;
  assign o_dbg.state     = r_state;
  assign o_dbg.v_at_top  = w_v_at_top;

`ifdef VTG_LOOKAHEAD_EN
  assign hPosNext = w_h_next;
  assign vPosNext = w_v_next;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced raster (15 clocks x 10 lines);
// the lookahead ports are exercised when VTG_LOOKAHEAD_EN is defined.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  // Reduced raster: h -7..7 (FP -7,-6; sync -5..-3; BP -2,-1), v -4..5
  // (FP -4; sync -3,-2; BP -1); 150 clocks and 48 active pixels per frame.
  localparam int H_START = -7;
  localparam int H_LAST  = 7;
  localparam int V_START = -4;
  localparam int V_LAST  = 5;
  localparam int HS_LO   = -5;
  localparam int HS_HI   = -3;
  localparam int VS_LO   = -3;
  localparam int VS_HI   = -2;

  logic                      clk;
  logic                      reset_n;
  logic                      run;
  logic signed [H_POS_W-1:0] hPosCounter;
  logic signed [V_POS_W-1:0] vPosCounter;
  logic                      hSync, vSync, inActiveDisplay, lineStart, frameStart, running;
  logic [3:0]                frameCount;
  vtg_dbg_t                  dbg;
`ifdef VTG_LOOKAHEAD_EN
  logic signed [H_POS_W-1:0] hPosNext;
  logic signed [V_POS_W-1:0] vPosNext;
`endif

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .FC_W(4)
  ) dut (
    .pixelClock(clk), .reset_n(reset_n), .run(run),
    .hPosCounter(hPosCounter), .vPosCounter(vPosCounter),
`ifdef VTG_LOOKAHEAD_EN
    .hPosNext(hPosNext), .vPosNext(vPosNext),
`endif
    .hSync(hSync), .vSync(vSync), .inActiveDisplay(inActiveDisplay),
    .lineStart(lineStart), .frameStart(frameStart), .frameCount(frameCount),
    .running(running), .o_dbg(dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string pfx, input logic [3:0] fc_exp);
    check({pfx, "_hpos"}, hPosCounter, H_START);
    check({pfx, "_vpos"}, vPosCounter, V_START);
    check({pfx, "_hsync"}, hSync, 0);
    check({pfx, "_vsync"}, vSync, 0);
    check({pfx, "_active"}, inActiveDisplay, 0);
    check({pfx, "_linestart"}, lineStart, 0);
    check({pfx, "_framestart"}, frameStart, 0);
    check({pfx, "_running"}, running, 0);
    check({pfx, "_fc"}, frameCount, fc_exp);
    check({pfx, "_state"}, dbg.state, ST_IDLE);
  endtask

  task automatic wait_pos(input string tag, input int h, input int v, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (hPosCounter == h && vPosCounter == v) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check({tag, "_reached"}, found, 1);
  endtask

  int m_line, m_hs, m_vs, m_act, m_fs, m_win_err, m_cont_err, m_fc_err;

  // Samples n consecutive cycles of continuous raster, starting at the current one.
  task automatic measure(input int n);
    logic signed [31:0] h, v, ph, pv, eh, ev;
    logic [3:0] pfc, e;
    m_line = 0; m_hs = 0; m_vs = 0; m_act = 0; m_fs = 0;
    m_win_err = 0; m_cont_err = 0; m_fc_err = 0;
    ph = 0; pv = 0; pfc = frameCount;
    for (int i = 0; i < n; i++) begin
      h = hPosCounter;
      v = vPosCounter;
      if (i > 0) begin
        eh = (ph == H_LAST) ? H_START : ph + 1;
        ev = (ph == H_LAST) ? ((pv == V_LAST) ? V_START : pv + 1) : pv;
        if (h != eh || v != ev) m_cont_err++;
        if (frameCount != pfc) begin
          if (exp_q.size() == 0) m_fc_err++;
          else begin
            e = exp_q.pop_front();
            if (frameCount != e) m_fc_err++;
          end
          if (!(h == H_START && v == V_START)) m_fc_err++;
        end
      end
      m_line += int'(lineStart);
      m_hs   += int'(hSync);
      m_vs   += int'(vSync);
      m_act  += int'(inActiveDisplay);
      m_fs   += int'(frameStart);
      if (hSync != (h >= HS_LO && h <= HS_HI)) m_win_err++;
      if (vSync != (v >= VS_LO && v <= VS_HI)) m_win_err++;
      if (inActiveDisplay != (h >= 0 && v >= 0)) m_win_err++;
      if (lineStart != (h == H_START)) m_win_err++;
      if (frameStart != (h == 0 && v == 0)) m_win_err++;
      if (running != 1'b1) m_win_err++;
      ph = h; pv = v; pfc = frameCount;
      step();
    end
  endtask

`ifdef VTG_LOOKAHEAD_EN
  int                        la_cnt = 0;
  int                        la_err = 0;
  logic                      la_valid = 1'b0;
  logic signed [H_POS_W-1:0] la_h;
  logic signed [V_POS_W-1:0] la_v;
  always @(negedge clk) begin
    if (la_valid && reset_n) begin
      la_cnt++;
      if (hPosCounter != la_h || vPosCounter != la_v) la_err++;
    end
    la_h     = hPosNext;
    la_v     = vPosNext;
    la_valid = reset_n;
  end
`endif

  int n_drain, n_idle, len;

  initial begin
    reset_n = 1'b0;
    run     = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst", 4'd0);
    reset_n = 1'b1;
    repeat (3) step();
    check_reset_outputs("idle_hold", 4'd0);

    // two frames of free run
    run = 1'b1;
    step();
    check("first_hpos", hPosCounter, H_START);
    check("first_vpos", vPosCounter, V_START);
    check("first_linestart", lineStart, 1);
    check("first_running", running, 1);
    exp_q.push_back(4'd1);
    measure(300);
    check("f2_lines", m_line, 20);
    check("f2_hsync_cycles", m_hs, 60);
    check("f2_vsync_cycles", m_vs, 60);
    check("f2_active_cycles", m_act, 96);
    check("f2_framestarts", m_fs, 2);
    check("f2_window_err", m_win_err, 0);
    check("f2_continuity_err", m_cont_err, 0);
    check("f2_fc_seq_err", m_fc_err, 0);
    check("f2_fc_q_left", exp_q.size(), 0);
    check("f2_end_fc", frameCount, 2);
    check("f2_end_hpos", hPosCounter, H_START);

    // run drops mid-frame: drain to the frame end, then idle
    wait_pos("drain", 0, 2, 200);
    run = 1'b0;
    n_drain = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (!running) break;
      n_drain++;
    end
    check("drain_cycles", n_drain, 52);
    check_reset_outputs("drain_idle", 4'd3);
    repeat (5) step();
    check_reset_outputs("drain_idle_hold", 4'd3);

    // run drops then returns within the frame: no discontinuity
    run = 1'b1;
    step();
    check("rerun_linestart", lineStart, 1);
    n_drain = 0; n_idle = 0; len = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0 && hPosCounter == H_START && vPosCounter == V_START) begin
        len = cyc;
        break;
      end
      if (!running) n_idle++;
      if (dbg.state == ST_DRAIN) n_drain++;
      if (hPosCounter == 0 && vPosCounter == 2) run = 1'b0;
      if (hPosCounter == 0 && vPosCounter == 4) run = 1'b1;
      step();
    end
    check("toggle_frame_len", len, 150);
    check("toggle_idle_cycles", n_idle, 0);
    check("toggle_drain_cycles", n_drain, 30);
    check("toggle_fc", frameCount, 4);

    // asynchronous reset in the middle of the active area
    wait_pos("mid_rst", 3, 2, 200);
    check("mid_rst_active_before", inActiveDisplay, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst", 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_held", 4'd0);
    reset_n = 1'b1;
    step();
    check("restart_hpos", hPosCounter, H_START);
    check("restart_vpos", vPosCounter, V_START);
    check("restart_linestart", lineStart, 1);

    // sixteen frames: frame counter wraps 15 -> 0
    for (int k = 1; k <= 15; k++) exp_q.push_back(4'(k));
    measure(2400);
    check("f16_lines", m_line, 160);
    check("f16_hsync_cycles", m_hs, 480);
    check("f16_vsync_cycles", m_vs, 480);
    check("f16_active_cycles", m_act, 768);
    check("f16_framestarts", m_fs, 16);
    check("f16_window_err", m_win_err, 0);
    check("f16_continuity_err", m_cont_err, 0);
    check("f16_fc_seq_err", m_fc_err, 0);
    check("f16_fc_q_left", exp_q.size(), 0);
    check("f16_fc_wrap", frameCount, 0);
    check("f16_end_vpos", vPosCounter, V_START);

    // stop at the frame end with run low on the last pixel
    wait_pos("last_px", H_LAST, V_LAST, 200);
    run = 1'b0;
    step();
    check_reset_outputs("stop_on_last", 4'd1);

`ifdef VTG_LOOKAHEAD_EN
    check("lookahead_err", la_err, 0);
    check("lookahead_cycles_seen", la_cnt > 0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates the raster timing that the pixel pipeline consumes: signed horizontal and vertical position counters, logical sync pulses, active-display enable, and line/frame strobes.
- Drives the sprite/tile drawers upstream of the TMDS serializer. This is the producing end of the position/sync interface those drawers read.
- Defaults give 720x480p60 at the 27 MHz crystal pixel clock.
- Blanking positions are negative, so active pixels start at (0,0).

Parameters:
- H_ACTIVE, 720, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 62, horizontal sync width (pixels)
- H_BP, 60, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 9, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 30, vertical back porch (lines)
- FC_W, 16, frame counter width

Ports:
- pixelClock  in  1  pixel clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- run  in  1  level; start/continue raster generation
- hPosCounter  out  11 signed  horizontal position
- vPosCounter  out  10 signed  vertical position
- hSync  out  1  horizontal sync, logical active-high
- vSync  out  1  vertical sync, logical active-high
- inActiveDisplay  out  1  high when hPos>=0 and vPos>=0
- lineStart  out  1  one-cycle strobe on first clock of each line
- frameStart  out  1  one-cycle strobe at hPos=0, vPos=0
- frameCount  out  FC_W  completed-frame counter
- running  out  1  high in RUN or DRAIN

Behaviour:
- Constants: H_BLANK = H_FP+H_SYNC+H_BP = 138; V_BLANK = 45.
- Horizontal sweep:
  - hPos counts -H_BLANK .. H_ACTIVE-1, then wraps to -H_BLANK.
  - Line order is front porch, sync, back porch, active.
  - hSync is high for hPos in [-(H_SYNC+H_BP), -H_BP-1]; default [-122, -61].
- Vertical sweep:
  - vPos advances only on the cycle hPos wraps. It counts -V_BLANK .. V_ACTIVE-1, then wraps.
  - vSync is high for vPos in [-(V_SYNC+V_BP), -V_BP-1]; default [-36, -31]. It spans whole lines and changes on the line wrap.
- All outputs are registered and mutually aligned. No combinational path from run to outputs.
- lineStart is high when hPos = -H_BLANK.
- frameStart is high when hPos = 0 and vPos = 0.
- frameCount increments (modulo 2^FC_W) on the cycle the final pixel of a frame (H_ACTIVE-1, V_ACTIVE-1) wraps.
- Reset (async assert, sync-safe release) sets:
  - state IDLE
  - hPos = -H_BLANK, vPos = -V_BLANK
  - hSync, vSync, inActiveDisplay, lineStart, frameStart, running all 0
  - frameCount 0
- FSM:
  - IDLE: counters held at (-H_BLANK, -V_BLANK); all strobes and syncs 0. If run=1, go to RUN. The first RUN cycle presents (-H_BLANK, -V_BLANK) with lineStart=1.
  - RUN: counters free-run. On run=0, go to DRAIN.
  - DRAIN: counters continue. run=1 returns to RUN with no discontinuity. At frame end (the wrap from (H_ACTIVE-1, V_ACTIVE-1)), go to IDLE; frameCount still increments on that wrap.
- run toggling inside a frame never truncates a frame or sync pulse.
- Reset mid-frame: immediate return to the reset values; no partial-frame count.
- Elaboration check: position ranges must fit the signed port widths. An $error is raised if H_ACTIVE-1 > 1023, H_BLANK > 1024, V_ACTIVE-1 > 511, or V_BLANK > 512.

Optional Feature:
- Macro: VTG_LOOKAHEAD_EN.
- Enabled: adds outputs hPosNext (11 signed) and vPosNext (10 signed), equal to the position presented on the following clock. This includes IDLE→RUN, wrap, and DRAIN→IDLE (IDLE next = reset position). Drawers use it to fetch bitmap data one cycle early without offset arithmetic.
- Disabled: ports absent. Core timing is identical.

Decomposition:
- Package video_timing_pkg:
  - 480p default localparams
  - position widths (H_POS_W = 11, V_POS_W = 10)
  - FSM state enum (IDLE, RUN, DRAIN)
- One natural sub-module: vtg_axis_counter, instantiated twice (h, v).
  - Behaviour: signed wrap counter with advance enable, hold-at-start input, and registered in-sync-window / at-start / at-last flags.

Test Plan:
- Reset, run=1 for 2 frames: first cycle (-138, -45) with lineStart=1; hSync high exactly 62 cycles per line (hPos -122..-61); 858 clocks per line; vSync high 6 lines (vPos -36..-31); 525 lines per frame.
- inActiveDisplay count over one frame = 345600 (720x480). frameStart pulses once per frame at (0,0); frameCount 0→1→2 at the wraps from (719, 479).
- run drops at vPos=100: running stays 1 until the (719, 479) wrap, then IDLE with counters at (-138, -45) and frameCount incremented; no partial frame.
- run drops at vPos=100 and reasserts at vPos=200: raster continuous, no IDLE entry, frame length still 450450 clocks.
- reset_n pulsed low at hPos=300, vPos=250 for 3 cycles mid-clock: outputs go to reset values asynchronously; frameCount=0; restart is clean after release.
- With VTG_LOOKAHEAD_EN: hPosNext/vPosNext equal the next-cycle hPos/vPos on every cycle, including wraps (719→-138) and the IDLE↔RUN transitions.
